// File: rtl/seq_pattern_detector_if.sv
// ---------------------------------------------------------------------------
// | Module  : seq_pattern_detector_if                                        |
// | Brief   : Config/stream/result bundle for seq_pattern_detector.          |
// |           cnt_clr is present only when SEQ_DET_CNT_CLR_EN is defined.    |
// | Revision: 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

interface seq_pattern_detector_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               in_bit;
`ifdef SEQ_DET_CNT_CLR_EN
  logic               cnt_clr;
`endif
  logic               armed;
  logic               detected;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit,
`ifdef SEQ_DET_CNT_CLR_EN
    output cnt_clr,
`endif
    input  armed, detected, match_count
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit,
`ifdef SEQ_DET_CNT_CLR_EN
    input  cnt_clr,
`endif
    output armed, detected, match_count
  );
endinterface

`default_nettype wire

// File: rtl/seq_pattern_detector.sv
// ---------------------------------------------------------------------------
// | Module  : seq_pattern_detector                                           |
// | Brief   : Run-time configurable serial pattern detector with registered  |
// |           match pulse and saturating counter. Optional synchronous       |
// |           counter clear enabled by macro SEQ_DET_CNT_CLR_EN.             |
// | Revision: 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module seq_pattern_detector #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  seq_pattern_detector_if.slave  bus
);

  typedef enum logic [0:0] {
    S_UNCFG = 1'b0,
    S_ARMED = 1'b1
  } state_e;

  state_e             state_q;
  logic               armed_q;
  logic               detected_q;
  logic [CNT_W-1:0]   count_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;

  logic [MAX_LEN-1:0] w_cand;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_fill_ok;
  logic               w_hit;
  logic               w_cfg_legal;
  logic [LEN_W-1:0]   fill_d;

  assign w_cand = {hist_q[MAX_LEN-2:0], bus.in_bit};

  // Mask selects the low len_q bits so pattern bits above the length are ignored.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  // Widened by one bit so fill_q + 1 cannot wrap when MAX_LEN + 1 is a power of two.
  assign w_fill_ok   = ({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q};
  assign w_hit       = w_fill_ok && (((w_cand ^ pat_q) & w_mask) == '0);
  assign w_cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
  assign fill_d      = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_UNCFG;
      armed_q    <= 1'b0;
      detected_q <= 1'b0;
      count_q    <= '0;
      hist_q     <= '0;
      fill_q     <= '0;
      pat_q      <= '0;
      len_q      <= '0;
      ovl_q      <= 1'b0;
    end else begin
      detected_q <= 1'b0;
      if (bus.cfg_we) begin
        // Configuration takes priority; a coincident in_bit is dropped.
        pat_q   <= bus.cfg_pattern;
        len_q   <= bus.cfg_len;
        ovl_q   <= bus.cfg_overlap;
        hist_q  <= '0;
        fill_q  <= '0;
        count_q <= '0;
        state_q <= w_cfg_legal ? S_ARMED : S_UNCFG;
        armed_q <= w_cfg_legal;
      end else if ((state_q == S_ARMED) && bus.in_valid) begin
        if (w_hit && !ovl_q) begin
          hist_q <= '0;
          fill_q <= '0;
        end else begin
          hist_q <= w_cand;
          fill_q <= fill_d;
        end
        if (w_hit) begin
          detected_q <= 1'b1;
          if (count_q != {CNT_W{1'b1}}) begin
            count_q <= count_q + CNT_W'(1);
          end
        end
      end
`ifdef SEQ_DET_CNT_CLR_EN
      if (bus.cnt_clr) begin
        count_q <= '0;
      end
`endif
    end
  end

  assign bus.armed       = armed_q;
  assign bus.detected    = detected_q;
  assign bus.match_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_detector.sv
// ---------------------------------------------------------------------------
// | Module  : tb_seq_pattern_detector                                        |
// | Brief   : Scoreboard bench for seq_pattern_detector (MAX_LEN=8, CNT_W=2).|
// | Revision: 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_pattern_detector;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  typedef struct packed {
    logic             armed;
    logic             det;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_pattern_detector_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  exp_t sb[$];

  // Reference model: an explicit list of received bits rather than a shift register.
  bit         m_armed;
  bit [7:0]   m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_cnt;
  bit         mq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_match();
    if (mq.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (mq[mq.size() - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_armed = 1'b0; m_pat = '0; m_len = 0; m_ovl = 1'b0; m_cnt = 0;
    mq.delete();
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("armed", 32'(bus.armed), 32'(e.armed));
      chk("detected", 32'(bus.detected), 32'(e.det));
      chk("match_count", 32'(bus.match_count), 32'(e.cnt));
      if (bus.detected === 1'b1) pulses++;
    end
  end

  task automatic step(input bit we, input bit [7:0] pat, input bit [3:0] len,
                      input bit ovl, input bit v, input bit b);
    exp_t e;
    bit   det;
    @(negedge clk);
    #1;
    bus.cfg_we      = we;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ovl;
    bus.in_valid    = v;
    bus.in_bit      = b;
    det = 1'b0;
    if (we) begin
      m_pat = pat; m_len = int'(len); m_ovl = ovl;
      m_armed = (len >= 1) && (len <= MAX_LEN);
      mq.delete();
      m_cnt = 0;
    end else if (m_armed && v) begin
      mq.push_back(b);
      if (mq.size() > MAX_LEN) void'(mq.pop_front());
      if (model_match()) begin
        det = 1'b1;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!m_ovl) mq.delete();
      end
    end
    e.armed = m_armed;
    e.det   = det;
    e.cnt   = CNT_W'(m_cnt);
    sb.push_back(e);
  endtask

  task automatic cfg(input bit [7:0] pat, input bit [3:0] len, input bit ovl);
    step(1'b1, pat, len, ovl, 1'b0, 1'b0);
  endtask

  task automatic send(input bit b);
    step(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #2;
    chk("rst_armed", 32'(bus.armed), 32'd0);
    chk("rst_detected", 32'(bus.detected), 32'd0);
    chk("rst_count", 32'(bus.match_count), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0;
`ifdef SEQ_DET_CNT_CLR_EN
    bus.cnt_clr = 1'b0;
`endif
    model_reset();
    #12;
    chk("reset_armed", 32'(bus.armed), 32'd0);
    chk("reset_detected", 32'(bus.detected), 32'd0);
    chk("reset_count", 32'(bus.match_count), 32'd0);
    @(negedge clk); #1; rst = 1'b0;

    // Overlapping 010 on stream 01010
    pulses = 0;
    cfg(8'b010, 4'd3, 1'b1);
    foreach (bus.cfg_pattern[i]) if (i < 5) send(((5'b01010 >> (4 - i)) & 1) != 0);
    idle(1);
    chk("t1_pulses", 32'(pulses), 32'd2);
    chk("t1_count", 32'(bus.match_count), 32'd2);

    // Non-overlapping on the same stream
    pulses = 0;
    cfg(8'b010, 4'd3, 1'b0);
    foreach (bus.cfg_pattern[i]) if (i < 5) send(((5'b01010 >> (4 - i)) & 1) != 0);
    idle(1);
    chk("t2_pulses", 32'(pulses), 32'd1);
    chk("t2_count", 32'(bus.match_count), 32'd1);

    // Gapped 8'hA5, MSB first
    pulses = 0;
    cfg(8'hA5, 4'd8, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      send(((8'hA5 >> i) & 1) != 0);
      idle(int'($urandom_range(1, 3)));
    end
    chk("t3_pulses", 32'(pulses), 32'd1);

    // Illegal lengths 0 and MAX_LEN+1, then a legal reload
    pulses = 0;
    cfg(8'h00, 4'd0, 1'b1);
    for (int i = 0; i < 20; i++) send(1'($urandom));
    cfg(8'h00, 4'(MAX_LEN + 1), 1'b1);
    for (int i = 0; i < 20; i++) send(1'($urandom));
    idle(1);
    chk("t4_pulses", 32'(pulses), 32'd0);
    chk("t4_armed", 32'(bus.armed), 32'd0);
    chk("t4_count", 32'(bus.match_count), 32'd0);
    cfg(8'h03, 4'd2, 1'b1);
    idle(1);
    chk("t4_rearm", 32'(bus.armed), 32'd1);

    // Saturation: len=1, pattern 1, six ones
    pulses = 0;
    cfg(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 6; i++) send(1'b1);
    idle(1);
    chk("t5_pulses", 32'(pulses), 32'd6);
    chk("t5_count", 32'(bus.match_count), 32'd3);

    // Reset mid-pattern, re-arm, final bit alone must not match
    pulses = 0;
    cfg(8'b010, 4'd3, 1'b1);
    send(1'b0);
    send(1'b1);
    idle(1);
    rst_pulse();
    cfg(8'b010, 4'd3, 1'b1);
    send(1'b0);
    idle(2);
    chk("t6_pulses", 32'(pulses), 32'd0);

    // cfg_we coincident with in_valid: bit dropped
    step(1'b1, 8'h01, 4'd1, 1'b1, 1'b1, 1'b1);
    idle(1);
    chk("t6_coincident_count", 32'(bus.match_count), 32'd0);
    send(1'b1);
    idle(1);
    chk("t6_after_count", 32'(bus.match_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
